// File: rtl/solver_job_sender.sv
// solver_job_sender
//   Sends one solver job downstream to solver_manager. A job is an output address, a zoom
//   word and a limb count. It is sent as this sequence of typed words:
//   ADDR, ZOOM, REAL x N, IMAG x N, END.
//   The limbs come from an external limb RAM. That RAM has one cycle of read latency.
//
// Ports
//   clock, reset                  single rising-edge clock, synchronous active-high reset
//   job_valid / job_ready         job header handshake (address, zoom, last limb index)
//   job_out_addr, job_zoom        header words, captured on accept
//   job_last_limb                 N-1, where N is the limb count per bank
//   limb_rd_en/imag/idx           limb RAM read request (imag selects the c_imag bank)
//   limb_rd_data                  limb RAM data, valid the cycle after limb_rd_en
//   fifo_valid/data_type/data     registered word output toward solver_manager
//   fifo_ready                    downstream accept
//   busy                          a job is in progress
//   jobs_sent                     count of completed jobs, wraps at 16 bits
//
// State table
//   S_IDLE  | waiting for a job header
//   S_ADDR  | ADDR word presented
//   S_ZOOM  | ZOOM word presented
//   S_FETCH | limb RAM read strobe for the current section/index
//   S_LOAD  | capture limb RAM data into the output word
//   S_SEND  | limb word presented
//   S_END   | END word presented
module solver_job_sender #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [31:0]                job_out_addr,
  input  logic [31:0]                job_zoom,
  input  logic [LIMB_INDEX_BITS-1:0] job_last_limb,
  output logic                       limb_rd_en,
  output logic                       limb_rd_imag,
  output logic [LIMB_INDEX_BITS-1:0] limb_rd_idx,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_rd_data,
  output logic                       fifo_valid,
  output logic [2:0]                 fifo_data_type,
  output logic [31:0]                fifo_data,
  input  logic                       fifo_ready,
  output logic                       busy,
  output logic [15:0]                jobs_sent
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ZOOM, S_FETCH, S_LOAD, S_SEND, S_END
  } state_t;

  localparam logic [2:0] TYPE_ADDR = 3'd0;
  localparam logic [2:0] TYPE_ZOOM = 3'd1;
  localparam logic [2:0] TYPE_REAL = 3'd2;
  localparam logic [2:0] TYPE_IMAG = 3'd3;
  localparam logic [2:0] TYPE_END  = 3'd4;

  state_t                     state, state_nxt;
  logic [31:0]                zoom_q, zoom_nxt;
  logic [LIMB_INDEX_BITS-1:0] last_q, last_nxt;
  logic [LIMB_INDEX_BITS-1:0] idx_q, idx_nxt;
  logic                       imag_q, imag_nxt;
  logic                       valid_nxt;
  logic [2:0]                 type_nxt;
  logic [31:0]                data_nxt;
  logic [15:0]                jobs_nxt;
  logic                       xfer;

  assign xfer         = fifo_valid && fifo_ready;
  assign job_ready    = (state == S_IDLE) && !reset;
  assign busy         = (state != S_IDLE);
  assign limb_rd_en   = (state == S_FETCH);
  assign limb_rd_imag = imag_q;
  assign limb_rd_idx  = idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      zoom_q         <= '0;
      last_q         <= '0;
      idx_q          <= '0;
      imag_q         <= 1'b0;
      fifo_valid     <= 1'b0;
      fifo_data_type <= TYPE_ADDR;
      fifo_data      <= '0;
      jobs_sent      <= '0;
    end else begin
      state          <= state_nxt;
      zoom_q         <= zoom_nxt;
      last_q         <= last_nxt;
      idx_q          <= idx_nxt;
      imag_q         <= imag_nxt;
      fifo_valid     <= valid_nxt;
      fifo_data_type <= type_nxt;
      fifo_data      <= data_nxt;
      jobs_sent      <= jobs_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    zoom_nxt  = zoom_q;
    last_nxt  = last_q;
    idx_nxt   = idx_q;
    imag_nxt  = imag_q;
    valid_nxt = fifo_valid;
    type_nxt  = fifo_data_type;
    data_nxt  = fifo_data;
    jobs_nxt  = jobs_sent;

    case (state)
      S_IDLE: begin
        if (job_valid) begin
          // The address is loaded straight into the output word, so only zoom needs a copy.
          zoom_nxt  = job_zoom;
          last_nxt  = job_last_limb;
          valid_nxt = 1'b1;
          type_nxt  = TYPE_ADDR;
          data_nxt  = job_out_addr;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          type_nxt  = TYPE_ZOOM;
          data_nxt  = zoom_q;
          state_nxt = S_ZOOM;
        end
      end
      S_ZOOM: begin
        if (xfer) begin
          valid_nxt = 1'b0;
          imag_nxt  = 1'b0;
          idx_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        data_nxt  = 32'(limb_rd_data);
        type_nxt  = imag_q ? TYPE_IMAG : TYPE_REAL;
        valid_nxt = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q != last_q) begin
            idx_nxt   = idx_q + 1'b1;
            valid_nxt = 1'b0;
            state_nxt = S_FETCH;
          end else if (!imag_q) begin
            imag_nxt  = 1'b1;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
            state_nxt = S_FETCH;
          end else begin
            type_nxt  = TYPE_END;
            data_nxt  = '0;
            state_nxt = S_END;
          end
        end
      end
      S_END: begin
        if (xfer) begin
          valid_nxt = 1'b0;
          jobs_nxt  = jobs_sent + 16'd1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_solver_job_sender.sv
// tb_solver_job_sender
//   Directed bench for solver_job_sender. A behavioural limb RAM has one cycle of read
//   latency. Each scenario task runs stimulus and compares word streams, cycle timing and
//   counters against values that the bench computes itself.
module tb_solver_job_sender;
  localparam int LIB = 6;
  localparam int LSB = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            job_valid;
  logic            job_ready;
  logic [31:0]     job_out_addr;
  logic [31:0]     job_zoom;
  logic [LIB-1:0]  job_last_limb;
  logic            limb_rd_en;
  logic            limb_rd_imag;
  logic [LIB-1:0]  limb_rd_idx;
  logic [LSB-1:0]  limb_rd_data;
  logic            fifo_valid;
  logic [2:0]      fifo_data_type;
  logic [31:0]     fifo_data;
  logic            fifo_ready;
  logic            busy;
  logic [15:0]     jobs_sent;

  int errors = 0;
  int checks = 0;

  logic [LSB-1:0] real_mem [0:63];
  logic [LSB-1:0] imag_mem [0:63];
  logic [2:0]     exp_type [0:135];
  logic [31:0]    exp_data [0:135];

  solver_job_sender #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_out_addr(job_out_addr), .job_zoom(job_zoom), .job_last_limb(job_last_limb),
    .limb_rd_en(limb_rd_en), .limb_rd_imag(limb_rd_imag), .limb_rd_idx(limb_rd_idx),
    .limb_rd_data(limb_rd_data),
    .fifo_valid(fifo_valid), .fifo_data_type(fifo_data_type), .fifo_data(fifo_data),
    .fifo_ready(fifo_ready), .busy(busy), .jobs_sent(jobs_sent)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (limb_rd_en) limb_rd_data <= limb_rd_imag ? imag_mem[limb_rd_idx] : real_mem[limb_rd_idx];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; job_valid = 1'b0; fifo_ready = 1'b1;
    job_out_addr = '0; job_zoom = '0; job_last_limb = '0;
    step(); step();
    checks++;
    if (fifo_valid !== 1'b0 || fifo_data_type !== 3'd0 || fifo_data !== 32'd0 ||
        jobs_sent !== 16'd0 || limb_rd_en !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b type=%0d data=%h jobs=%0d rd_en=%0b busy=%0b ready=%0b required 0/0/0/0/0/0/0",
               fifo_valid, fifo_data_type, fifo_data, jobs_sent, limb_rd_en, busy, job_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b required 1", job_ready);
    end
  endtask

  // Present a header and return in cycle 1, the first cycle after the accept edge.
  task automatic start_job(input logic [31:0] a, input logic [31:0] z,
                           input logic [LIB-1:0] last, input bit keep_valid);
    job_valid = 1'b1; job_out_addr = a; job_zoom = z; job_last_limb = last;
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: got %0b required 1", job_ready);
    end
    step();
    if (!keep_valid) job_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_busy: busy=%0b job_ready=%0b required 1/0", busy, job_ready);
    end
  endtask

  // Collect one whole job stream. The bench computes the expected stream from real_mem/imag_mem.
  // The word at index stall_w is held off for stall_len cycles with fifo_ready low.
  task automatic run_stream(input int n, input logic [31:0] a, input logic [31:0] z,
                            input int stall_w, input int stall_len,
                            output int first_c, output int end_c);
    int total, wi, fi, stalled, c;
    total = 2 * n + 3;
    exp_type[0] = 3'd0; exp_data[0] = a;
    exp_type[1] = 3'd1; exp_data[1] = z;
    for (int i = 0; i < n; i++) begin
      exp_type[2 + i]     = 3'd2; exp_data[2 + i]     = {24'd0, real_mem[i]};
      exp_type[2 + n + i] = 3'd3; exp_data[2 + n + i] = {24'd0, imag_mem[i]};
    end
    exp_type[total - 1] = 3'd4; exp_data[total - 1] = 32'd0;
    wi = 0; fi = 0; stalled = 0; c = 1; first_c = -1; end_c = -1;
    while (wi < total && c < 2000) begin
      if (limb_rd_en) begin
        checks++;
        if (fifo_valid !== 1'b0 || limb_rd_imag !== (fi >= n) ||
            limb_rd_idx !== LIB'(fi % n) || fi >= 2 * n) begin
          errors++;
          $display("FAIL fetch_%0d: valid=%0b imag=%0b idx=%0d required 0/%0b/%0d",
                   fi, fifo_valid, limb_rd_imag, limb_rd_idx, fi >= n, fi % n);
        end
        fi++;
      end
      if (fifo_valid) begin
        if (wi == stall_w && stalled < stall_len) begin
          fifo_ready = 1'b0;
          stalled++;
          checks++;
          if (fifo_data_type !== exp_type[wi] || fifo_data !== exp_data[wi]) begin
            errors++;
            $display("FAIL stall_hold_%0d: type=%0d data=%h required %0d/%h",
                     stalled, fifo_data_type, fifo_data, exp_type[wi], exp_data[wi]);
          end
        end else begin
          fifo_ready = 1'b1;
          checks++;
          if (fifo_data_type !== exp_type[wi] || fifo_data !== exp_data[wi]) begin
            errors++;
            $display("FAIL word_%0d: type=%0d data=%h required %0d/%h",
                     wi, fifo_data_type, fifo_data, exp_type[wi], exp_data[wi]);
          end
          if (wi == 0) first_c = c;
          if (wi == total - 1) end_c = c;
          wi++;
        end
      end else begin
        fifo_ready = 1'b1;
      end
      step();
      c++;
    end
    fifo_ready = 1'b1;
    checks++;
    if (wi < total || fi != 2 * n) begin
      errors++;
      $display("FAIL stream_complete: words=%0d fetches=%0d required %0d/%0d", wi, fi, total, 2 * n);
    end
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || fifo_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_end: job_ready=%0b busy=%0b valid=%0b required 1/0/0", job_ready, busy, fifo_valid);
    end
  endtask

  task automatic check_timing(input string name, input int first_c, input int end_c,
                              input int exp_end, input int exp_jobs);
    checks++;
    if (first_c !== 1 || end_c !== exp_end) begin
      errors++;
      $display("FAIL %s_timing: addr_c=%0d end_c=%0d required 1/%0d", name, first_c, end_c, exp_end);
    end
    checks++;
    if (jobs_sent !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL %s_jobs_sent: got %0d required %0d", name, jobs_sent, exp_jobs);
    end
  endtask

  task automatic load_n3();
    real_mem[0] = 8'd3; real_mem[1] = 8'd4; real_mem[2] = 8'd5;
    imag_mem[0] = 8'd6; imag_mem[1] = 8'd7; imag_mem[2] = 8'd8;
  endtask

  task automatic test_basic();
    int fc, ec;
    load_n3();
    start_job(32'd1, 32'd2, 6'd2, 1'b0);
    run_stream(3, 32'd1, 32'd2, -1, 0, fc, ec);
    check_timing("basic", fc, ec, 21, 1);
  endtask

  task automatic test_stall();
    int fc, ec;
    load_n3();
    start_job(32'd1, 32'd2, 6'd2, 1'b0);
    run_stream(3, 32'd1, 32'd2, 6, 3, fc, ec);
    check_timing("stall", fc, ec, 24, 2);
  endtask

  task automatic test_single_limb();
    int fc, ec;
    real_mem[0] = 8'hA5; imag_mem[0] = 8'hA5;
    start_job(32'hDEAD_BEEF, 32'h1234_5678, 6'd0, 1'b0);
    run_stream(1, 32'hDEAD_BEEF, 32'h1234_5678, -1, 0, fc, ec);
    check_timing("n1", fc, ec, 9, 3);
  endtask

  task automatic test_max_limbs();
    int fc, ec;
    for (int i = 0; i < 64; i++) begin
      real_mem[i] = 8'(i);
      imag_mem[i] = 8'(i);
    end
    start_job(32'h0000_0040, 32'h0000_0080, 6'd63, 1'b0);
    run_stream(64, 32'h0000_0040, 32'h0000_0080, -1, 0, fc, ec);
    check_timing("n64", fc, ec, 387, 4);
  endtask

  task automatic test_reset_mid_job();
    int fc, ec, c;
    bit found;
    load_n3();
    start_job(32'd1, 32'd2, 6'd2, 1'b0);
    fifo_ready = 1'b1;
    found = 1'b0;
    c = 0;
    while (!found && c < 50) begin
      if (fifo_valid && fifo_data_type == 3'd2 && fifo_data == 32'd4) found = 1'b1;
      else begin step(); c++; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach: REAL limb 1 not presented within 50 cycles, required presented");
    end
    reset = 1'b1;
    step();
    checks++;
    if (fifo_valid !== 1'b0 || busy !== 1'b0 || jobs_sent !== 16'd0 || limb_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%0b busy=%0b jobs=%0d rd_en=%0b required 0/0/0/0",
               fifo_valid, busy, jobs_sent, limb_rd_en);
    end
    reset = 1'b0;
    #1;
    start_job(32'h55, 32'h66, 6'd2, 1'b0);
    run_stream(3, 32'h55, 32'h66, -1, 0, fc, ec);
    check_timing("midreset_new", fc, ec, 21, 1);
  endtask

  task automatic test_back_to_back();
    int fc, ec;
    real_mem[0] = 8'h11; real_mem[1] = 8'h12;
    imag_mem[0] = 8'h21; imag_mem[1] = 8'h22;
    start_job(32'h100, 32'h200, 6'd1, 1'b1);
    // The header changes while the first job runs; the first job must still send the header it latched.
    job_out_addr = 32'h300; job_zoom = 32'h400;
    run_stream(2, 32'h100, 32'h200, -1, 0, fc, ec);
    check_timing("b2b_first", fc, ec, 15, 2);
    step();
    job_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || fifo_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%0b valid=%0b required 1/1", busy, fifo_valid);
    end
    run_stream(2, 32'h300, 32'h400, -1, 0, fc, ec);
    check_timing("b2b_second", fc, ec, 15, 3);
    step(); step(); step();
    checks++;
    if (busy !== 1'b0 || jobs_sent !== 16'd3) begin
      errors++;
      $display("FAIL b2b_idle: busy=%0b jobs=%0d required 0/3", busy, jobs_sent);
    end
  endtask

  initial begin
    reset = 1'b1;
    job_valid = 1'b0;
    fifo_ready = 1'b1;
    job_out_addr = '0; job_zoom = '0; job_last_limb = '0;
    for (int i = 0; i < 64; i++) begin
      real_mem[i] = '0;
      imag_mem[i] = '0;
    end
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_single_limb();
    test_max_limbs();
    test_reset_mid_job();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
